vector_lane_sequencer: RTL and testbench

Single-lane vector execution sequencer that sits directly upstream of the vector register file. It accepts one element-wise vector command (vd = vs1 op vs2, length vl), walks the element index, and reads both source operands through the register file's two read ports. It computes the result in a one-stage pipeline and writes each element back through the register file's single write port. It issues one element per cycle and pulses `done` when the last element is written.

---
 rtl/vlane_pkg.sv | 27 ++
 rtl/vlane_alu.sv | 33 +++
 rtl/vector_lane_sequencer.sv | 167 ++++++++++++++++
 tb/tb_vector_lane_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vlane_pkg.sv
// Shared types for the vector lane sequencer: op codes, FSM states and latched command fields.
package vlane_pkg;

  typedef enum logic [2:0] {
    VOP_ADD = 3'd0,
    VOP_SUB = 3'd1,
    VOP_AND = 3'd2,
    VOP_OR  = 3'd3,
    VOP_XOR = 3'd4,
    VOP_SLL = 3'd5,
    VOP_SRL = 3'd6,
    VOP_MIN = 3'd7
  } vop_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Width-independent command fields; register/element addresses live in the top.
  typedef struct packed {
    vop_e op;
    logic scalar_en;
  } vlane_cmd_t;

endpackage

// File: rtl/vlane_alu.sv
// Combinational element ALU: (op, a, b) -> result. Shifts use only the low log2(DATA_WIDTH) bits of b.
import vlane_pkg::*;

module vlane_alu #(
  parameter int DATA_WIDTH = 32
) (
  input  vop_e                  i_op,
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  output logic [DATA_WIDTH-1:0] o_result
);

  localparam int SHW = $clog2(DATA_WIDTH);

  logic [SHW-1:0] w_shamt;
  assign w_shamt = i_b[SHW-1:0];

  always_comb begin
    o_result = '0;
    case (i_op)
      VOP_ADD: o_result = i_a + i_b;
      VOP_SUB: o_result = i_a - i_b;
      VOP_AND: o_result = i_a & i_b;
      VOP_OR:  o_result = i_a | i_b;
      VOP_XOR: o_result = i_a ^ i_b;
      VOP_SLL: o_result = i_a << w_shamt;
      VOP_SRL: o_result = i_a >> w_shamt;
      VOP_MIN: o_result = ($signed(i_a) < $signed(i_b)) ? i_a : i_b;
      default: o_result = '0;
    endcase
  end

endmodule

// File: rtl/vector_lane_sequencer.sv
// Single-lane vector sequencer: one element per cycle through a one-stage write pipeline.
// Optional scalar second operand enabled by defining VLANE_SCALAR_EN.
import vlane_pkg::*;

module vector_lane_sequencer #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_ELE    = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [2:0]            cmd_op,
  input  logic [ADDR_WIDTH-1:0] cmd_vd,
  input  logic [ADDR_WIDTH-1:0] cmd_vs1,
  input  logic [ADDR_WIDTH-1:0] cmd_vs2,
  input  logic [ADDR_WIDTH:0]   cmd_vl,
`ifdef VLANE_SCALAR_EN
  input  logic                  cmd_scalar_en,
  input  logic [DATA_WIDTH-1:0] cmd_scalar,
`endif
  output logic [ADDR_WIDTH-1:0] rAddr1_1,
  output logic [ADDR_WIDTH-1:0] rAddr2_1,
  input  logic [DATA_WIDTH-1:0] rData1,
  output logic [ADDR_WIDTH-1:0] rAddr1_2,
  output logic [ADDR_WIDTH-1:0] rAddr2_2,
  input  logic [DATA_WIDTH-1:0] rData2,
  output logic [ADDR_WIDTH-1:0] wAddr1,
  output logic [ADDR_WIDTH-1:0] wAddr2,
  output logic [DATA_WIDTH-1:0] wData,
  output logic                  wEnable,
  output logic                  busy,
  output logic                  done
);

  localparam logic [ADDR_WIDTH:0] LP_NUM_ELE = (ADDR_WIDTH + 1)'(NUM_ELE);
  localparam logic [ADDR_WIDTH:0] LP_ONE     = (ADDR_WIDTH + 1)'(1);

  state_e                r_state;
  vlane_cmd_t            r_cmd;
  logic [ADDR_WIDTH-1:0] r_vd;
  logic [ADDR_WIDTH-1:0] r_vs1;
  logic [ADDR_WIDTH-1:0] r_vs2;
  logic [ADDR_WIDTH:0]   r_vl;
  logic [ADDR_WIDTH-1:0] r_idx;
  logic                  r_cmd_ready;
  logic                  r_done;
  logic                  r_wb_valid;
  logic [ADDR_WIDTH-1:0] r_wb_idx;
  logic [DATA_WIDTH-1:0] r_wb_data;

  logic [ADDR_WIDTH:0]   w_eff_vl;
  logic                  w_run;
  logic                  w_port2_on;
  logic                  w_last;
  logic [DATA_WIDTH-1:0] w_op_b;
  logic [DATA_WIDTH-1:0] w_alu_result;

  assign w_eff_vl   = (cmd_vl > LP_NUM_ELE) ? LP_NUM_ELE : cmd_vl;
  assign w_run      = (r_state == ST_RUN);
  assign w_port2_on = w_run && !r_cmd.scalar_en;
  assign w_last     = ({1'b0, r_idx} == (r_vl - LP_ONE));

  assign rAddr1_1 = w_run ? r_vs1 : '0;
  assign rAddr2_1 = w_run ? r_idx : '0;
  assign rAddr1_2 = w_port2_on ? r_vs2 : '0;
  assign rAddr2_2 = w_port2_on ? r_idx : '0;

`ifdef VLANE_SCALAR_EN
  logic [DATA_WIDTH-1:0] r_scalar;
  assign w_op_b = r_cmd.scalar_en ? r_scalar : rData2;
`else
  assign w_op_b = rData2;
`endif

  vlane_alu #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_alu (
    .i_op    (r_cmd.op),
    .i_a     (rData1),
    .i_b     (w_op_b),
    .o_result(w_alu_result)
  );

  // FSM, element counter and write stage share one register process.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_cmd       <= '0;
      r_vd        <= '0;
      r_vs1       <= '0;
      r_vs2       <= '0;
      r_vl        <= '0;
      r_idx       <= '0;
      r_cmd_ready <= 1'b1;
      r_done      <= 1'b0;
      r_wb_valid  <= 1'b0;
      r_wb_idx    <= '0;
      r_wb_data   <= '0;
    end else begin
      r_wb_valid <= 1'b0;
      r_done     <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            r_cmd.op    <= vop_e'(cmd_op);
`ifdef VLANE_SCALAR_EN
            r_cmd.scalar_en <= cmd_scalar_en;
`else
            r_cmd.scalar_en <= 1'b0;
`endif
            r_vd        <= cmd_vd;
            r_vs1       <= cmd_vs1;
            r_vs2       <= cmd_vs2;
            r_vl        <= w_eff_vl;
            r_idx       <= '0;
            r_cmd_ready <= 1'b0;
            if (w_eff_vl != '0) begin
              r_state <= ST_RUN;
            end else begin
              r_state <= ST_DRAIN;
              r_done  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          r_wb_valid <= 1'b1;
          r_wb_idx   <= r_idx;
          r_wb_data  <= w_alu_result;
          r_idx      <= r_idx + 1'b1;
          if (w_last) begin
            r_state <= ST_DRAIN;
            r_done  <= 1'b1;
          end
        end
        ST_DRAIN: begin
          r_state     <= ST_IDLE;
          r_cmd_ready <= 1'b1;
        end
        default: begin
          r_state     <= ST_IDLE;
          r_cmd_ready <= 1'b1;
        end
      endcase
    end
  end

`ifdef VLANE_SCALAR_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_scalar <= '0;
    end else if (r_state == ST_IDLE && cmd_valid) begin
      r_scalar <= cmd_scalar;
    end
  end
`endif

  assign cmd_ready = r_cmd_ready;
  assign busy      = !r_cmd_ready;
  assign done      = r_done;
  assign wEnable   = r_wb_valid;
  assign wAddr1    = r_vd;
  assign wAddr2    = r_wb_idx;
  assign wData     = r_wb_data;

endmodule

// File: tb/tb_vector_lane_sequencer.sv
// Self-checking bench for vector_lane_sequencer with a behavioural register file and op model.
`timescale 1ns/1ps
module tb_vector_lane_sequencer;

  logic        clk;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [4:0]  cmd_vd, cmd_vs1, cmd_vs2;
  logic [5:0]  cmd_vl;
  logic        cmd_scalar_en;
  logic [31:0] cmd_scalar;
  logic [4:0]  rAddr1_1, rAddr2_1, rAddr1_2, rAddr2_2;
  logic [31:0] rData1, rData2;
  logic [4:0]  wAddr1, wAddr2;
  logic [31:0] wData;
  logic        wEnable, busy, done;

  logic [31:0] rf [32][32];
  logic [31:0] exp_d [2][32];
  int n_pass;
  int n_total;

  assign rData1 = rf[rAddr1_1][rAddr2_1];
  assign rData2 = rf[rAddr1_2][rAddr2_2];

  vector_lane_sequencer #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .NUM_ELE(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_vd(cmd_vd), .cmd_vs1(cmd_vs1), .cmd_vs2(cmd_vs2), .cmd_vl(cmd_vl),
`ifdef VLANE_SCALAR_EN
    .cmd_scalar_en(cmd_scalar_en), .cmd_scalar(cmd_scalar),
`endif
    .rAddr1_1(rAddr1_1), .rAddr2_1(rAddr2_1), .rData1(rData1),
    .rAddr1_2(rAddr1_2), .rAddr2_2(rAddr2_2), .rData2(rData2),
    .wAddr1(wAddr1), .wAddr2(wAddr2), .wData(wData), .wEnable(wEnable),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] ref_op(input int op, input logic [31:0] a, input logic [31:0] b);
    int sh;
    sh = int'(b % 32);
    case (op)
      0: return a + b;
      1: return a - b;
      2: return a & b;
      3: return a | b;
      4: return a ^ b;
      5: return a << sh;
      6: return a >> sh;
      default: return ($signed(a) < $signed(b)) ? a : b;
    endcase
  endfunction

  // Expected results are taken from the register file as it stands before the command.
  task automatic build_exp(input int slot, input int op, input int vs1, input int vs2, input int eff);
    for (int i = 0; i < eff; i++)
      exp_d[slot][i] = ref_op(op, rf[vs1][i], cmd_scalar_en ? cmd_scalar : rf[vs2][i]);
  endtask

  task automatic start_cmd(input int op, input int vd, input int vs1, input int vs2, input int vl, input bit hold);
    @(negedge clk);
    n_total++;
    if (cmd_ready !== 1'b1) $display("FAIL start_ready: cmd_ready=%0b want 1", cmd_ready);
    else n_pass++;
    cmd_op = 3'(op); cmd_vd = 5'(vd); cmd_vs1 = 5'(vs1); cmd_vs2 = 5'(vs2); cmd_vl = 6'(vl);
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) cmd_valid = 1'b0;
  endtask

  task automatic check_cycles(input string name, input int slot, input int eff, input int vd, input int vs1, input int vs2);
    bit exp_we, exp_done, exp_rdy, sc;
    sc = cmd_scalar_en;
    for (int c = 1; c <= eff + 2; c++) begin
      @(negedge clk);
      exp_we   = (c >= 2) && (c <= eff + 1);
      exp_done = (eff == 0) ? (c == 1) : (c == eff + 1);
      exp_rdy  = (c == eff + 2);
      n_total += 4;
      if (wEnable !== exp_we) $display("FAIL %s_we cyc%0d: got %0b want %0b", name, c, wEnable, exp_we); else n_pass++;
      if (done !== exp_done) $display("FAIL %s_done cyc%0d: got %0b want %0b", name, c, done, exp_done); else n_pass++;
      if (cmd_ready !== exp_rdy) $display("FAIL %s_ready cyc%0d: got %0b want %0b", name, c, cmd_ready, exp_rdy); else n_pass++;
      if (busy !== !exp_rdy) $display("FAIL %s_busy cyc%0d: got %0b want %0b", name, c, busy, !exp_rdy); else n_pass++;
      if (exp_we) begin
        n_total += 3;
        if (wAddr1 !== 5'(vd)) $display("FAIL %s_wAddr1 cyc%0d: got %0d want %0d", name, c, wAddr1, vd); else n_pass++;
        if (wAddr2 !== 5'(c - 2)) $display("FAIL %s_wAddr2 cyc%0d: got %0d want %0d", name, c, wAddr2, c - 2); else n_pass++;
        if (wData !== exp_d[slot][c-2]) $display("FAIL %s_wData cyc%0d: got %h want %h", name, c, wData, exp_d[slot][c-2]); else n_pass++;
      end
      if (wEnable === 1'b1) rf[wAddr1][wAddr2] = wData;
      if (c <= eff) begin
        n_total += 3;
        if (rAddr1_1 !== 5'(vs1) || rAddr2_1 !== 5'(c - 1))
          $display("FAIL %s_rd1 cyc%0d: got %0d/%0d want %0d/%0d", name, c, rAddr1_1, rAddr2_1, vs1, c - 1);
        else n_pass++;
        if (rAddr1_2 !== (sc ? 5'd0 : 5'(vs2)))
          $display("FAIL %s_rd2v cyc%0d: got %0d want %0d", name, c, rAddr1_2, sc ? 0 : vs2);
        else n_pass++;
        if (rAddr2_2 !== (sc ? 5'd0 : 5'(c - 1)))
          $display("FAIL %s_rd2e cyc%0d: got %0d want %0d", name, c, rAddr2_2, sc ? 0 : c - 1);
        else n_pass++;
      end
    end
    $display("txn %s: vl_eff=%0d vd=%0d vs1=%0d vs2=%0d checked", name, eff, vd, vs1, vs2);
  endtask

  task automatic run_one(input string name, input int op, input int vd, input int vs1, input int vs2, input int vl);
    int eff;
    eff = (vl > 32) ? 32 : vl;
    build_exp(0, op, vs1, vs2, eff);
    start_cmd(op, vd, vs1, vs2, vl, 1'b0);
    check_cycles(name, 0, eff, vd, vs1, vs2);
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    n_total += 5;
    if (cmd_ready !== 1'b1) $display("FAIL reset_ready: got %0b want 1", cmd_ready); else n_pass++;
    if ({busy, done, wEnable} !== 3'b000) $display("FAIL reset_flags: got %b want 000", {busy, done, wEnable}); else n_pass++;
    if ({rAddr1_1, rAddr2_1, rAddr1_2, rAddr2_2} !== 20'd0) $display("FAIL reset_raddr: got %h want 0", {rAddr1_1, rAddr2_1, rAddr1_2, rAddr2_2}); else n_pass++;
    if ({wAddr1, wAddr2} !== 10'd0) $display("FAIL reset_waddr: got %h want 0", {wAddr1, wAddr2}); else n_pass++;
    if (wData !== 32'd0) $display("FAIL reset_wdata: got %h want 0", wData); else n_pass++;
    reset_n = 1'b1;
    $display("txn reset: outputs checked");
  endtask

  task automatic test_add_vl4;
    for (int i = 0; i < 4; i++) begin
      rf[1][i] = 32'(i + 1);
      rf[2][i] = 32'(10 * (i + 1));
    end
    run_one("add_vl4", 0, 3, 1, 2, 4);
    for (int i = 0; i < 4; i++) begin
      n_total++;
      if (rf[3][i] !== 32'(11 * (i + 1))) $display("FAIL add_vl4_rf[%0d]: got %0d want %0d", i, rf[3][i], 11 * (i + 1));
      else n_pass++;
    end
  endtask

  task automatic test_corner_ops;
    int          ops [3];
    logic [31:0] av [3];
    logic [31:0] bv [3];
    logic [31:0] rv [3];
    ops[0] = 1; av[0] = 32'd0;          bv[0] = 32'd1;  rv[0] = 32'hFFFF_FFFF;
    ops[1] = 7; av[1] = 32'h8000_0000;  bv[1] = 32'd5;  rv[1] = 32'h8000_0000;
    ops[2] = 5; av[2] = 32'd1;          bv[2] = 32'd33; rv[2] = 32'd2;
    for (int k = 0; k < 3; k++) begin
      rf[10][0] = av[k];
      rf[11][0] = bv[k];
      run_one("corner", ops[k], 12, 10, 11, 1);
      n_total++;
      if (rf[12][0] !== rv[k]) $display("FAIL corner_op%0d: got %h want %h", ops[k], rf[12][0], rv[k]);
      else n_pass++;
    end
  endtask

  task automatic test_random_ops;
    int op, vd, vs1, vs2, vl;
    for (int t = 0; t < 10; t++) begin
      op  = $urandom_range(0, 7);
      vd  = $urandom_range(0, 31);
      vs1 = $urandom_range(0, 31);
      vs2 = $urandom_range(0, 31);
      vl  = $urandom_range(1, 32);
      for (int i = 0; i < 32; i++) begin
        rf[vs1][i] = $urandom;
        rf[vs2][i] = $urandom;
      end
      run_one($sformatf("rand_op%0d", op), op, vd, vs1, vs2, vl);
    end
  endtask

  task automatic test_zero_clamp;
    run_one("vl0", 0, 4, 5, 6, 0);
    for (int i = 0; i < 32; i++) begin
      rf[5][i] = $urandom;
      rf[6][i] = $urandom;
    end
    run_one("vl40", 4, 7, 5, 6, 40);
  endtask

  task automatic test_alias;
    logic [31:0] orig [32];
    for (int i = 0; i < 32; i++) begin
      rf[2][i] = $urandom;
      rf[5][i] = 32'd1;
      orig[i]  = rf[2][i];
    end
    run_one("alias", 0, 2, 2, 5, 32);
    for (int i = 0; i < 32; i++) begin
      n_total++;
      if (rf[2][i] !== orig[i] + 32'd1) $display("FAIL alias_rf[%0d]: got %h want %h", i, rf[2][i], orig[i] + 32'd1);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid;
    int writes;
    for (int i = 0; i < 32; i++) begin
      rf[7][i] = $urandom;
      rf[8][i] = $urandom;
    end
    build_exp(0, 0, 7, 8, 8);
    start_cmd(0, 6, 7, 8, 8, 1'b0);
    @(negedge clk);
    @(negedge clk);
    n_total += 2;
    if (wEnable !== 1'b1) $display("FAIL rmid_we_c2: got %0b want 1", wEnable); else n_pass++;
    if (wData !== exp_d[0][0]) $display("FAIL rmid_data_c2: got %h want %h", wData, exp_d[0][0]); else n_pass++;
    if (wEnable === 1'b1) rf[wAddr1][wAddr2] = wData;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    n_total += 3;
    if (wEnable !== 1'b0) $display("FAIL rmid_we_drop: got %0b want 0", wEnable); else n_pass++;
    if (cmd_ready !== 1'b1) $display("FAIL rmid_ready: got %0b want 1", cmd_ready); else n_pass++;
    if (busy !== 1'b0) $display("FAIL rmid_busy: got %0b want 0", busy); else n_pass++;
    @(negedge clk);
    reset_n = 1'b1;
    writes = 0;
    repeat (12) begin
      @(negedge clk);
      if (wEnable === 1'b1) writes++;
    end
    n_total++;
    if (writes !== 0) $display("FAIL rmid_writes_after: got %0d want 0", writes); else n_pass++;
    $display("txn reset_mid: vl=8 interrupted in cycle 3");
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 32; i++) begin
      rf[21][i] = $urandom; rf[22][i] = $urandom;
      rf[24][i] = $urandom; rf[25][i] = $urandom;
    end
    build_exp(0, 0, 21, 22, 5);
    build_exp(1, 4, 24, 25, 3);
    start_cmd(0, 20, 21, 22, 5, 1'b1);
    cmd_op = 3'd4; cmd_vd = 5'd23; cmd_vs1 = 5'd24; cmd_vs2 = 5'd25; cmd_vl = 6'd3;
    check_cycles("b2b_first", 0, 5, 20, 21, 22);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    check_cycles("b2b_second", 1, 3, 23, 24, 25);
  endtask

`ifdef VLANE_SCALAR_EN
  task automatic test_scalar;
    for (int i = 0; i < 32; i++) begin
      rf[27][i] = $urandom;
      rf[28][i] = $urandom;
    end
    cmd_scalar_en = 1'b1;
    cmd_scalar    = 32'hFF;
    run_one("scalar_xor", 4, 26, 27, 28, 8);
    for (int i = 0; i < 8; i++) begin
      n_total++;
      if (rf[26][i] !== (rf[27][i] ^ 32'hFF)) $display("FAIL scalar_rf[%0d]: got %h want %h", i, rf[26][i], rf[27][i] ^ 32'hFF);
      else n_pass++;
    end
    cmd_scalar_en = 1'b0;
    cmd_scalar    = 32'd0;
  endtask
`endif

  initial begin
    n_pass = 0; n_total = 0;
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0;
    cmd_vd = '0; cmd_vs1 = '0; cmd_vs2 = '0; cmd_vl = '0;
    cmd_scalar_en = 1'b0; cmd_scalar = '0;
    for (int r = 0; r < 32; r++)
      for (int e = 0; e < 32; e++)
        rf[r][e] = '0;
    test_reset;
    test_add_vl4;
    test_corner_ops;
    test_random_ops;
    test_zero_clamp;
    test_alias;
    test_reset_mid;
    test_back_to_back;
`ifdef VLANE_SCALAR_EN
    test_scalar;
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
